// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the AES-256 inverse cipher.
package aes_pkg;

  localparam int unsigned NK    = 8;
  localparam int unsigned NR    = 14;
  localparam int unsigned NW    = 4 * (NR + 1);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned KEY_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Rcon[i] for i = 1..7; only the first (least significant) byte is nonzero.
  function automatic logic [7:0] rcon(input logic [2:0] i);
    return 8'(8'h01 << (i - 3'd1));
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] rk,
  input  logic             last,
  output logic [BLK_W-1:0] result_c
);

  logic [BLK_W-1:0] ark_c;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09)};
  endfunction

  // Row r shifts right by r: output column c takes input column (c - r) mod 4.
  always_comb begin
    ark_c = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark_c[8*(4*c+r) +: 8] = inv_sbox(state[8*(4*((c-r+4)%4)+r) +: 8]) ^ rk[8*(4*c+r) +: 8];
      end
    end
  end

  always_comb begin
    result_c = ark_c;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        result_c[32*c +: 32] = inv_mix_col(ark_c[32*c +: 32]);
      end
    end
  end

endmodule

// File: rtl/aes256_decrypt.sv
// Iterative AES-256 inverse cipher: per-start key expansion (one word/cycle), then 14 inverse rounds.
module aes256_decrypt
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] ciphertext_i,
  input  logic [KEY_W-1:0] key_i,
  output logic [BLK_W-1:0] plaintext,
  output logic             done,
  output logic             busy
);

  fsm_e             fsm;
  logic [5:0]       widx;
  logic [3:0]       rnd;
  logic [BLK_W-1:0] state;
  logic [31:0]      w [NW];

  logic [31:0]      temp_c;
  logic [31:0]      new_word_c;
  logic [3:0]       rk_sel_c;
  logic [5:0]       rk_base_c;
  logic [BLK_W-1:0] rk_c;
  logic [BLK_W-1:0] round_out_c;
  logic             last_c;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Key schedule step for word widx; RotWord moves byte 0 (LSB) to byte 3.
  always_comb begin
    temp_c = w[6'(widx - 6'd1)];
    if (widx[2:0] == 3'd0) begin
      temp_c = sub_word({temp_c[7:0], temp_c[31:8]}) ^ {24'h0, rcon(widx[5:3])};
    end else if (widx[2:0] == 3'd4) begin
      temp_c = sub_word(temp_c);
    end
    new_word_c = w[6'(widx - 6'd8)] ^ temp_c;
  end

  always_comb begin
    unique case (fsm)
      ST_INIT:  rk_sel_c = 4'(NR);
      ST_FINAL: rk_sel_c = 4'd0;
      default:  rk_sel_c = rnd;
    endcase
    rk_base_c = {rk_sel_c, 2'b00};
    rk_c = {w[6'(rk_base_c + 6'd3)], w[6'(rk_base_c + 6'd2)],
            w[6'(rk_base_c + 6'd1)], w[rk_base_c]};
    last_c = (fsm == ST_FINAL);
  end

  aes_inv_round u_inv_round (
    .state    (state),
    .rk       (rk_c),
    .last     (last_c),
    .result_c (round_out_c)
  );

  // Key words need no reset: every start rewrites w[0..7] before any are read.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      widx      <= '0;
      rnd       <= '0;
      state     <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (fsm)
        ST_IDLE: begin
          if (start) begin
            state <= ciphertext_i;
            for (int j = 0; j < int'(NK); j++) begin
              w[j] <= key_i[32*j +: 32];
            end
            widx <= 6'd8;
            busy <= 1'b1;
            fsm  <= ST_KEYEXP;
          end
        end
        ST_KEYEXP: begin
          w[widx] <= new_word_c;
          widx    <= widx + 6'd1;
          if (widx == 6'(NW - 1)) fsm <= ST_INIT;
        end
        ST_INIT: begin
          state <= state ^ rk_c;
          rnd   <= 4'(NR - 1);
          fsm   <= ST_ROUND;
        end
        ST_ROUND: begin
          state <= round_out_c;
          rnd   <= rnd - 4'd1;
          if (rnd == 4'd1) fsm <= ST_FINAL;
        end
        ST_FINAL: begin
          plaintext <= round_out_c;
          done      <= 1'b1;
          busy      <= 1'b0;
          fsm       <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
